// File: rtl/regfile_write_ctrl.sv
// Write-port owner for the 32x32 register file. After reset it clears registers 1-31.
// It then shares the port between core writeback (priority) and a valid/ready aux writer.
module regfile_write_ctrl #(
  parameter int STARVE_LIMIT   = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_we,
  input  logic [4:0]  core_wreg,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  input  logic        aux_wvalid,
  input  logic [4:0]  aux_wreg,
  input  logic [31:0] aux_wdata,
  output logic        aux_wready,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        rf_write_enable,
  output logic        init_busy
);

  localparam logic       S_CLEAR   = 1'b0;
  localparam logic       S_RUN     = 1'b1;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic       S_AFTER_R = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  // Handshake: an aux write transfers on a cycle where aux_wvalid && aux_wready;
  // the aux writer holds valid, reg and data stable until then. The core has no
  // handshake and must repeat its write request while core_stall is high.

  logic       state_q, state_d;
  logic [4:0] clr_idx_q, clr_idx_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       grant_core, grant_aux;

  always_comb begin
    state_d         = state_q;
    clr_idx_d       = clr_idx_q;
    wait_cnt_d      = wait_cnt_q;
    grant_core      = 1'b0;
    grant_aux       = 1'b0;
    core_stall      = 1'b0;
    aux_wready      = 1'b0;
    init_busy       = 1'b0;
    rf_write_enable = 1'b0;
    rf_write_reg    = 5'd0;
    rf_write_data   = 32'd0;

    if (!reset_n) begin
      core_stall = 1'b1;
      init_busy  = 1'b1;
    end else if (state_q == S_CLEAR) begin
      core_stall      = 1'b1;
      init_busy       = 1'b1;
      rf_write_enable = 1'b1;
      rf_write_reg    = clr_idx_q;
      clr_idx_d       = clr_idx_q + 5'd1;
      if (clr_idx_q == 5'd31) state_d = S_RUN;
    end else begin
      // A saturated wait counter forces the aux grant and stalls the core,
      // even when the core is not writing this cycle.
      if (aux_wvalid && (wait_cnt_q == LIMIT)) begin
        grant_aux  = 1'b1;
        core_stall = 1'b1;
      end else if (core_we) begin
        grant_core = 1'b1;
      end else if (aux_wvalid) begin
        grant_aux = 1'b1;
      end
      aux_wready = grant_aux;
      if (grant_aux) begin
        rf_write_reg    = aux_wreg;
        rf_write_data   = aux_wdata;
        rf_write_enable = (aux_wreg != 5'd0);
      end else if (grant_core) begin
        rf_write_reg    = core_wreg;
        rf_write_data   = core_wdata;
        rf_write_enable = (core_wreg != 5'd0);
      end
    end

    if (reset_n) begin
      if (aux_wvalid && aux_wready)    wait_cnt_d = 4'd0;
      else if (aux_wvalid && (wait_cnt_q != LIMIT)) wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_AFTER_R;
      clr_idx_q  <= 5'd1;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: clear sequence, arbitration table,
// starvation forcing, register-0 suppression, mid-clear reset, no-clear variant.
`timescale 1ns/1ps
module tb_regfile_write_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_we;
  logic [4:0]  core_wreg;
  logic [31:0] core_wdata;
  logic        aux_wvalid, aux_wvalid1;
  logic [4:0]  aux_wreg;
  logic [31:0] aux_wdata;
  logic        core_stall, aux_wready, rf_write_enable, init_busy;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        u1_core_stall, u1_aux_wready, u1_rf_write_enable, u1_init_busy;
  logic [4:0]  u1_rf_write_reg;
  logic [31:0] u1_rf_write_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        seed;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_write_ctrl #(.STARVE_LIMIT(4), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n),
    .core_we(core_we), .core_wreg(core_wreg), .core_wdata(core_wdata),
    .core_stall(core_stall),
    .aux_wvalid(aux_wvalid), .aux_wreg(aux_wreg), .aux_wdata(aux_wdata),
    .aux_wready(aux_wready),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable), .init_busy(init_busy)
  );

  regfile_write_ctrl #(.STARVE_LIMIT(4), .CLEAR_ON_RESET(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n),
    .core_we(1'b0), .core_wreg(core_wreg), .core_wdata(core_wdata),
    .core_stall(u1_core_stall),
    .aux_wvalid(aux_wvalid1), .aux_wreg(aux_wreg), .aux_wdata(aux_wdata),
    .aux_wready(u1_aux_wready),
    .rf_write_reg(u1_rf_write_reg), .rf_write_data(u1_rf_write_data),
    .rf_write_enable(u1_rf_write_enable), .init_busy(u1_init_busy)
  );

  // Register file model: register 0 reads as zero because it is never enabled.
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : (32'hA5A5_0000 | 32'(i));
    end else if (rf_write_enable) begin
      rf[rf_write_reg] <= rf_write_data;
    end
  end

  typedef struct {
    logic        core_we;
    logic [4:0]  core_wreg;
    logic [31:0] core_wdata;
    logic        aux_wvalid;
    logic [4:0]  aux_wreg;
    logic [31:0] aux_wdata;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        exp_ready;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_port(input string nm, input logic we, input logic [4:0] rg,
                          input logic [31:0] d, input logic rdy, input logic stl,
                          input logic bsy);
    chk({nm, " we"},    32'(rf_write_enable), 32'(we));
    chk({nm, " reg"},   32'(rf_write_reg),    32'(rg));
    chk({nm, " data"},  rf_write_data,        d);
    chk({nm, " ready"}, 32'(aux_wready),      32'(rdy));
    chk({nm, " stall"}, 32'(core_stall),      32'(stl));
    chk({nm, " busy"},  32'(init_busy),       32'(bsy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_we    = 1'b0;
    core_wreg  = 5'd0;
    core_wdata = 32'd0;
    aux_wvalid = 1'b0;
    aux_wreg   = 5'd0;
    aux_wdata  = 32'd0;
  endtask

  // Entered one time unit after a clock edge with the FSM in CLEAR at clr_idx 1.
  task automatic run_clear(input string nm);
    for (int k = 1; k <= 31; k++) begin
      #1;
      chk_port($sformatf("%s clr%0d", nm, k), 1'b1, 5'(k), 32'd0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    #1;
    chk_port({nm, " run"}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hCAFEF00D, 1'b1, 5'd9,  32'hCAFEF00D, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h11,       1'b0, 5'd0,  32'h11,       1'b1, 1'b0};
    vecs[5] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd3,  32'h44,       1'b1, 5'd3,  32'h33,       1'b0, 1'b0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h55,       1'b1, 5'd12, 32'h55,       1'b1, 1'b0};
    vecs[7] = '{1'b1, 5'd31, 32'h77777777, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'h77777777, 1'b0, 1'b0};

    seed        = 1'b1;
    reset_n     = 1'b0;
    aux_wvalid1 = 1'b0;
    idle_inputs();

    tick();
    seed = 1'b0;
    #1;
    chk_port("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("reset u1 busy", 32'(u1_init_busy), 32'd1);
    tick();

    // Release: u0 starts clearing, u1 goes straight to RUN and takes an aux write.
    reset_n     = 1'b1;
    aux_wvalid1 = 1'b1;
    aux_wreg    = 5'd4;
    aux_wdata   = 32'h0000000A;
    #1;
    chk("u1 busy",  32'(u1_init_busy),       32'd0);
    chk("u1 stall", 32'(u1_core_stall),      32'd0);
    chk("u1 ready", 32'(u1_aux_wready),      32'd1);
    chk("u1 we",    32'(u1_rf_write_enable), 32'd1);
    chk("u1 reg",   32'(u1_rf_write_reg),    32'd4);
    chk("u1 data",  u1_rf_write_data,        32'h0000000A);
    run_clear("init");
    aux_wvalid1 = 1'b0;
    for (int i = 0; i < 32; i++) chk($sformatf("rf%0d cleared", i), rf[i], 32'd0);

    for (int v = 0; v < 8; v++) begin
      tick();
      core_we    = vecs[v].core_we;
      core_wreg  = vecs[v].core_wreg;
      core_wdata = vecs[v].core_wdata;
      aux_wvalid = vecs[v].aux_wvalid;
      aux_wreg   = vecs[v].aux_wreg;
      aux_wdata  = vecs[v].aux_wdata;
      #1;
      chk_port($sformatf("vec%0d", v), vecs[v].exp_we, vecs[v].exp_reg, vecs[v].exp_data,
               vecs[v].exp_ready, vecs[v].exp_stall, 1'b0);
    end
    tick();
    idle_inputs();
    chk("rf5",  rf[5],  32'hDEADBEEF);
    chk("rf9",  rf[9],  32'hCAFEF00D);
    chk("rf0",  rf[0],  32'd0);
    chk("rf3",  rf[3],  32'h33);
    chk("rf12", rf[12], 32'h55);
    chk("rf31", rf[31], 32'h77777777);

    // Starvation: core keeps writing, aux waits four cycles then is forced in.
    core_we    = 1'b1;
    core_wreg  = 5'd6;
    core_wdata = 32'h6666;
    aux_wvalid = 1'b1;
    aux_wreg   = 5'd7;
    aux_wdata  = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_port($sformatf("starve wait%0d", i), 1'b1, 5'd6, 32'h6666, 1'b0, 1'b0, 1'b0);
      tick();
    end
    #1;
    chk_port("starve force", 1'b1, 5'd7, 32'h12345678, 1'b1, 1'b1, 1'b0);
    tick();
    aux_wvalid = 1'b0;
    #1;
    chk_port("after force", 1'b1, 5'd6, 32'h6666, 1'b0, 1'b0, 1'b0);
    chk("rf7", rf[7], 32'h12345678);
    tick();

    // Counter restarted from zero; force lands on a cycle without a core write.
    aux_wvalid = 1'b1;
    aux_wreg   = 5'd8;
    aux_wdata  = 32'h88;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_port($sformatf("rewait%0d", i), 1'b1, 5'd6, 32'h6666, 1'b0, 1'b0, 1'b0);
      tick();
    end
    core_we = 1'b0;
    #1;
    chk_port("force no core", 1'b1, 5'd8, 32'h88, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk_port("idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rf8", rf[8], 32'h88);
    tick();

    // Full reset, then a one-cycle reset pulse while register 17 is being cleared.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk_port($sformatf("pre clr%0d", k), 1'b1, 5'(k), 32'd0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    #1;
    chk_port("pre clr17", 1'b1, 5'd17, 32'd0, 1'b0, 1'b1, 1'b1);
    reset_n    = 1'b0;
    aux_wvalid = 1'b1;
    aux_wreg   = 5'd9;
    aux_wdata  = 32'h99;
    #1;
    chk_port("pulse", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    tick();
    reset_n = 1'b1;
    idle_inputs();
    run_clear("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
